// File: rtl/axi_slv_mem.sv
// AXI3 slave memory responder: INCR bursts of 16-byte beats on independent read and
// write channels, backed by an internal word array, with a sticky protocol-error flag.
module axi_slv_mem #(
  parameter int AW    = 32,
  parameter int DW    = 128,
  parameter int IDW   = 4,
  parameter int DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rstj,
  input  logic            stall,
  input  logic            arvalid,
  output logic            arready,
  input  logic [AW-1:0]   araddr,
  input  logic [3:0]      arlen,
  input  logic [2:0]      arprot,
  input  logic [IDW-1:0]  arid,
  output logic            rvalid,
  input  logic            rready,
  output logic [DW-1:0]   rdata,
  output logic            rlast,
  output logic [IDW-1:0]  rid,
  input  logic            awvalid,
  output logic            awready,
  input  logic [AW-1:0]   awaddr,
  input  logic [3:0]      awlen,
  input  logic [2:0]      awprot,
  input  logic [3:0]      awcache,
  input  logic [IDW-1:0]  awid,
  input  logic            wvalid,
  output logic            wready,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            wlast,
  input  logic [IDW-1:0]  wid,
  output logic            bvalid,
  input  logic            bready,
  output logic [IDW-1:0]  bid,
  output logic            err
);

  localparam int IXW = $clog2(DEPTH);
  localparam int SW  = DW / 8;

  typedef enum logic {R_IDLE, R_BURST} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [DW-1:0] mem [DEPTH];

  r_state_e       r_state_q, r_state_d;
  w_state_e       w_state_q, w_state_d;
  logic           rdy_q;
  logic [IXW-1:0] r_idx_q, r_idx_d, w_idx_q, w_idx_d;
  logic [3:0]     r_cnt_q, r_cnt_d, w_cnt_q, w_cnt_d;
  logic [IDW-1:0] rid_q, rid_d, bid_q, bid_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           err_q, err_d;
  logic           arpend_q, arpend_d;
  logic           ar_hs, r_hs, aw_hs, w_hs, b_hs;

  logic unused_ok;
  assign unused_ok = ^{arprot, awprot, awcache, araddr[AW-1:IXW+4], araddr[3:0],
                       awaddr[AW-1:IXW+4], awaddr[3:0]};

  // stall only masks the handshake signals; state and data are untouched
  assign arready = (r_state_q == R_IDLE) & rdy_q & ~stall;
  assign rvalid  = (r_state_q == R_BURST) & ~stall;
  assign rlast   = (r_state_q == R_BURST) & (r_cnt_q == 4'd0);
  assign rdata   = rdata_q;
  assign rid     = rid_q;
  assign awready = (w_state_q == W_IDLE) & rdy_q & ~stall;
  assign wready  = (w_state_q == W_DATA) & ~stall;
  assign bvalid  = (w_state_q == W_RESP) & ~stall;
  assign bid     = bid_q;
  assign err     = err_q;

  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_cnt_d   = r_cnt_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_idx_d   = araddr[4 +: IXW];
          r_cnt_d   = arlen;
          rid_d     = arid;
          rdata_d   = mem[araddr[4 +: IXW]];
          r_state_d = R_BURST;
        end
      end
      default: begin
        if (r_hs) begin
          if (r_cnt_q == 4'd0) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d = r_cnt_q - 4'd1;
            r_idx_d = r_idx_q + IXW'(1);
            rdata_d = mem[r_idx_q + IXW'(1)];
          end
        end
      end
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_cnt_d   = w_cnt_q;
    bid_d     = bid_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          w_idx_d   = awaddr[4 +: IXW];
          w_cnt_d   = awlen;
          bid_d     = awid;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          if (w_cnt_q == 4'd0) begin
            w_state_d = W_RESP;
          end else begin
            w_cnt_d = w_cnt_q - 4'd1;
            w_idx_d = w_idx_q + IXW'(1);
          end
        end
      end
      default: begin
        if (b_hs) w_state_d = W_IDLE;
      end
    endcase
  end

  // arpend_q remembers an address request left waiting, so a withdrawn request is caught
  assign arpend_d = arvalid & ~arready;
  assign err_d = err_q
               | (w_hs & ((wlast != (w_cnt_q == 4'd0)) | (wid != bid_q)))
               | (arpend_q & ~arvalid);

  always_ff @(posedge clk or negedge rstj) begin
    if (!rstj) begin
      rdy_q     <= 1'b0;
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      r_idx_q   <= '0;
      w_idx_q   <= '0;
      r_cnt_q   <= '0;
      w_cnt_q   <= '0;
      rid_q     <= '0;
      bid_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      arpend_q  <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      r_idx_q   <= r_idx_d;
      w_idx_q   <= w_idx_d;
      r_cnt_q   <= r_cnt_d;
      w_cnt_q   <= w_cnt_d;
      rid_q     <= rid_d;
      bid_q     <= bid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      arpend_q  <= arpend_d;
    end
  end

  // Memory has no reset so contents survive a mid-burst reset
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int b = 0; b < SW; b++) begin
        if (wstrb[b]) mem[w_idx_q][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_slv_mem.sv
// Directed bench for axi_slv_mem: bursts, strobes, wrap, backpressure, errors, reset.
module tb_axi_slv_mem;

  localparam int AW = 32, DW = 128, IDW = 4, DEPTH = 1024;

  logic clk = 1'b0, rstj = 1'b0, stall = 1'b0;
  logic arvalid = 1'b0, arready;
  logic [AW-1:0] araddr = '0;
  logic [3:0] arlen = '0;
  logic [2:0] arprot = '0;
  logic [IDW-1:0] arid = '0;
  logic rvalid, rready = 1'b0;
  logic [DW-1:0] rdata;
  logic rlast;
  logic [IDW-1:0] rid;
  logic awvalid = 1'b0, awready;
  logic [AW-1:0] awaddr = '0;
  logic [3:0] awlen = '0;
  logic [2:0] awprot = '0;
  logic [3:0] awcache = '0;
  logic [IDW-1:0] awid = '0;
  logic wvalid = 1'b0, wready;
  logic [DW-1:0] wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic wlast = 1'b0;
  logic [IDW-1:0] wid = '0;
  logic bvalid, bready = 1'b0;
  logic [IDW-1:0] bid;
  logic err;

  int total = 0, bad = 0;
  logic [DW-1:0] wbuf [16];
  logic [DW-1:0] rbuf [16];
  int rcount;

  always #5 clk = ~clk;

  axi_slv_mem #(.AW(AW), .DW(DW), .IDW(IDW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstj(rstj), .stall(stall),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arprot(arprot), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rid(rid),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awprot(awprot), .awcache(awcache), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wid(wid),
    .bvalid(bvalid), .bready(bready), .bid(bid), .err(err)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one write burst from wbuf; beat bad_last gets an inverted wlast.
  task automatic wr_burst(input logic [AW-1:0] addr, input logic [3:0] len,
                          input logic [IDW-1:0] id, input logic [DW/8-1:0] strb,
                          input int bad_last, input logic [IDW-1:0] widv, input int err_beat);
    int n;
    awvalid = 1'b1; awaddr = addr; awlen = len; awid = id;
    #1;
    for (n = 0; n < 50 && !awready; n++) begin @(negedge clk); #1; end
    chk("aw_ready", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    #1 chk("w_ready_next", wready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = strb; wid = widv;
      wlast = (i == int'(len)) ^ (i == bad_last);
      #1;
      for (n = 0; n < 50 && !wready; n++) begin @(negedge clk); #1; end
      chk("w_beat_ready", wready, 1);
      @(negedge clk);
      if (i == err_beat) begin #1 chk("err_set", err, 1); end
    end
    wvalid = 1'b0; wlast = 1'b0;
    #1 chk("b_valid", bvalid, 1);
    chk("b_id", bid, id);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    #1 chk("b_done", bvalid, 0);
    chk("aw_ready_again", awready, 1);
  endtask

  // Reads a burst into rbuf; rr/st give rready and stall per cycle after AR.
  task automatic rd_burst(input logic [AW-1:0] addr, input logic [3:0] len,
                          input logic [IDW-1:0] id, input logic [31:0] rr, input logic [31:0] st);
    int n, cyc;
    logic held;
    logic [DW-1:0] hv;
    arvalid = 1'b1; araddr = addr; arlen = len; arid = id; rready = 1'b0;
    #1;
    for (n = 0; n < 50 && !arready; n++) begin @(negedge clk); #1; end
    chk("ar_ready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    rcount = 0; cyc = 0; held = 1'b0; hv = '0;
    while (rcount <= int'(len) && cyc < 100) begin
      rready = rr[cyc & 31]; stall = st[cyc & 31];
      #1;
      if (held) chk("r_stable", rdata, hv);
      if (stall) chk("r_stall_masks", rvalid, 0);
      else if (cyc == 0) chk("r_valid_first", rvalid, 1);
      if (rvalid && rready) begin
        rbuf[rcount] = rdata;
        chk("r_id", rid, id);
        chk("r_last", rlast, rcount == int'(len));
        rcount++;
        held = 1'b0;
      end else begin
        held = 1'b1; hv = rdata;
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0; stall = 1'b0;
    #1 chk("r_beats", rcount, int'(len) + 1);
    chk("r_idle_valid", rvalid, 0);
    chk("ar_ready_again", arready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", rid, 0);
    chk("rst_bid", bid, 0);
    @(negedge clk);
    rstj = 1'b1;
    #1 chk("rdy_not_yet", arready, 0);
    @(negedge clk);
    #1 chk("rdy_arready", arready, 1);
    chk("rdy_awready", awready, 1);

    // Basic 4-beat write/read
    for (int i = 0; i < 4; i++) wbuf[i] = 128'(i + 1);
    wr_burst(32'h100, 4'd3, 4'd5, 16'hFFFF, -1, 4'd5, -1);
    rd_burst(32'h100, 4'd3, 4'd2, 32'hFFFF_FFFF, 32'h0);
    chk("rd_b0", rbuf[0], 128'd1);
    chk("rd_b1", rbuf[1], 128'd2);
    chk("rd_b2", rbuf[2], 128'd3);
    chk("rd_b3", rbuf[3], 128'd4);
    chk("err_clean", err, 0);

    // Byte strobes on word 7
    wbuf[0] = {128{1'b1}};
    wr_burst(32'h70, 4'd0, 4'd1, 16'hFFFF, -1, 4'd1, -1);
    wbuf[0] = '0;
    wr_burst(32'h70, 4'd0, 4'd1, 16'h000F, -1, 4'd1, -1);
    rd_burst(32'h70, 4'd0, 4'd3, 32'hFFFF_FFFF, 32'h0);
    chk("strobe_word7", rbuf[0], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000);

    // Index wrap past DEPTH-1, upper address bits ignored on read
    for (int i = 0; i < 4; i++) wbuf[i] = 128'hA0 + 128'(i);
    wr_burst(32'h3FE0, 4'd3, 4'd7, 16'hFFFF, -1, 4'd7, -1);
    rd_burst(32'h1000_3FE0, 4'd3, 4'd4, 32'hFFFF_FFFF, 32'h0);
    chk("wrap_b0", rbuf[0], 128'hA0);
    chk("wrap_b1", rbuf[1], 128'hA1);
    chk("wrap_b2", rbuf[2], 128'hA2);
    chk("wrap_b3", rbuf[3], 128'hA3);
    rd_burst(32'h0, 4'd1, 4'd4, 32'hFFFF_FFFF, 32'h0);
    chk("wrap_word0", rbuf[0], 128'hA2);
    chk("wrap_word1", rbuf[1], 128'hA3);

    // 8-beat read with rready 1,0,0,1... and a 2-cycle stall
    for (int i = 0; i < 8; i++) wbuf[i] = {4{32'h1111_0000 + 32'(i)}};
    wr_burst(32'h200, 4'd7, 4'd3, 16'hFFFF, -1, 4'd3, -1);
    rd_burst(32'h200, 4'd7, 4'd6, 32'hFFFF_FFF9, 32'h0000_0030);
    for (int i = 0; i < 8; i++) chk($sformatf("bp_b%0d", i), rbuf[i], {4{32'h1111_0000 + 32'(i)}});
    chk("err_before_proto", err, 0);

    // wlast asserted on beat 2 of 4
    for (int i = 0; i < 4; i++) wbuf[i] = 128'h50 + 128'(i);
    wr_burst(32'h300, 4'd3, 4'd2, 16'hFFFF, 1, 4'd2, 1);
    chk("err_sticky", err, 1);

    // Reset during beat 3 of a read
    arvalid = 1'b1; araddr = 32'h100; arlen = 4'd3; arid = 4'd3; rready = 1'b1;
    #1 chk("mid_arready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("mid_beat3", rdata, 128'd3);
    chk("mid_rvalid", rvalid, 1);
    rready = 1'b0;
    rstj = 1'b0;
    #1 chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_err", err, 0);
    @(negedge clk);
    @(negedge clk);
    rstj = 1'b1;
    #1 chk("mid_rel_arready0", arready, 0);
    @(negedge clk);
    #1 chk("mid_rel_arready1", arready, 1);
    rd_burst(32'h100, 4'd3, 4'd9, 32'hFFFF_FFFF, 32'h0);
    chk("post_b0", rbuf[0], 128'd1);
    chk("post_b3", rbuf[3], 128'd4);
    chk("post_err", err, 0);

    // Mismatched wid on the first beat
    for (int i = 0; i < 2; i++) wbuf[i] = 128'h77;
    wr_burst(32'h400, 4'd1, 4'd1, 16'hFFFF, -1, 4'd9, 0);
    chk("wid_err_sticky", err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_slv_mem.md
# axi_slv_mem

AXI3 slave memory responder for the 128-bit AXI master port of the codec blocks (jpgenc and siblings) in the block-level testbench. It accepts INCR bursts on independent read and write channels, backs them with an internal word array, and echoes transaction IDs. It is the responder end of the `axi_pub` master interface, and it also flags protocol violations from the master.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 128, data width; fixed 16-byte beats, `WSTRB` width `DW/8`
- `IDW`, 4, ID width
- `DEPTH`, 1024, memory depth in `DW` words; power of two

Ports:
- `clk`  in  1  sys clock; all logic on rising edge
- `rstj`  in  1  asynchronous active-low reset
- `stall`  in  1  test hook; forces `arready`/`awready`/`wready`/`rvalid`/`bvalid` low while high
- `arvalid`, `arready`  in/out  1  read address handshake
- `araddr`  in  AW  byte address
- `arlen`  in  4  beats minus one
- `arprot`  in  3  ignored
- `arid`  in  IDW  read ID
- `rvalid`  out  1  read data valid
- `rready`  in  1  read data accept
- `rdata`  out  DW  read data
- `rlast`  out  1  last read beat
- `rid`  out  IDW  echoed `arid`
- `awvalid`, `awready`  in/out  1  write address handshake
- `awaddr`  in  AW  byte address
- `awlen`  in  4  beats minus one
- `awprot`  in  3  ignored
- `awcache`  in  4  ignored
- `awid`  in  IDW  write ID
- `wvalid`  in  1  write data valid
- `wready`  out  1  write data accept
- `wdata`  in  DW  write data
- `wstrb`  in  DW/8  byte enables
- `wlast`  in  1  last write beat
- `wid`  in  IDW  write data ID
- `bvalid`  out  1  write response valid
- `bready`  in  1  write response accept
- `bid`  out  IDW  echoed `awid`
- `err`  out  1  sticky protocol-error flag; cleared only by reset

## Operation
- Word index: `addr[4 +: log2(DEPTH)]`. Low 4 address bits are ignored. Upper bits are dropped, so the index wraps modulo `DEPTH`. Burst index increments by 1 per beat and wraps from `DEPTH-1` to 0.
- Burst type and size are fixed at INCR and 16 bytes. `ARBURST`/`ARSIZE` are not ports.
- Read FSM `R_IDLE` -> `R_BURST`:
  - `R_IDLE`: `arready=1`. On `arvalid&arready`, capture index, `arlen`, `arid`; load `rdata<=mem[index]`; go to `R_BURST`.
  - `R_BURST`: `rvalid=1`, `rid`=captured ID, `rlast=(beat count==0)`. On `rvalid&rready`, decrement count, advance index, load the next word. On the last beat, return to `R_IDLE`.
- Write FSM `W_IDLE` -> `W_DATA` -> `W_RESP`:
  - `W_IDLE`: `awready=1`. On handshake, capture index, `awlen`, `awid`.
  - `W_DATA`: `wready=1`. Each `wvalid&wready` writes `mem[index]` byte-wise under `wstrb`, then advances index and count. Leave after `awlen+1` beats, counted; `wlast` is not used for the transition.
  - `W_RESP`: `bvalid=1`, `bid`=captured ID. On `bready`, return to `W_IDLE`.
- Read and write channels are fully independent. There is one outstanding burst per channel.
- `err` sets on any of:
  - `wlast` value differing from (count==0) on an accepted W beat
  - `wid` differing from the captured `awid` on an accepted W beat
  - `arvalid` dropping before its handshake
- Memory contents are not reset; they are X until written.

## Timing
- Reset values: `arready`, `awready`, `wready`, `rvalid`, `bvalid`, `rlast`, `err` = 0; `rdata`, `rid`, `bid` = 0.
- A `rdy` flop (reset 0) sets on the first `clk` after `rstj` rises. `arready`/`awready` = idle state & `rdy` & ~`stall`.
- AR handshake at cycle n -> `rvalid` at n+1. With `rready` held high: one beat per cycle, `rlast` at n+1+`arlen`, next `arready` at n+2+`arlen`.
- AW handshake at n -> `wready` at n+1. After the last W beat at m: `bvalid` at m+1. After B handshake at k: `awready` at k+1.
- `rvalid`, `rdata`, `rlast`, `rid` hold stable while `rready` is low. `bvalid`/`bid` hold until `bready`.
- `stall` masks valid/ready combinationally; FSM state and data are held. `stall` during `R_BURST` therefore drops `rvalid` without losing a beat.
- Same-word read and write in the same cycle: the read gets the old word (read-before-write); the write commits at that edge.
- Reset asserted mid-burst aborts both FSMs immediately to idle with outputs at reset values. Partially written memory is kept.

## Test plan
- Write burst: `awaddr=0x100`, `awlen=3`, `wdata`=1..4, full `wstrb`, `awid=5` -> `bvalid` 1 cycle after the 4th beat, `bid=5`. Reading `0x100`, `arlen=3`, `arid=2` -> `rdata` 1,2,3,4, `rlast` on beat 4, `rid=2`, `err=0`.
- Strobes: write `0xFF..FF` to word 7, then `wdata=0`, `wstrb=0x000F` -> read word 7 returns `0xFF..FF_FFFF_FF00_0000_00`.
- Wrap: `awaddr=(DEPTH-2)*16`, `awlen=3` -> beats land in words `DEPTH-2`, `DEPTH-1`, 0, 1; read back matches.
- Backpressure: `rready` toggled 1,0,0,1 and `stall` pulsed during an 8-beat read -> no beat lost or duplicated; `rdata` stable while stalled.
- Protocol errors: `wlast` on beat 2 of a 4-beat write -> `err=1` the next cycle; B response is still issued after beat 4. A mismatched `wid` likewise sets `err`.
- Reset mid-read: `rstj` low during beat 3 -> `rvalid=0` immediately; after release, `arready=1` one cycle later and a new read completes correctly.
